pipo_share_arbiter: RTL and testbench
=====================================

Name: pipo_share_arbiter

Overview:
Round-robin arbiter that shares one WIDTH-bit parallel-in/parallel-out holding register between N_REQ requesters. An FSM grants one requester at a time and loads its word into the register in a single cycle. It then holds the value stable for HOLD_CYCLES cycles so the downstream consumer can sample it. The block sits between several parallel word sources and a single shared output bus.

Parameters:
N_REQ, 4, number of requesters (2..16)
WIDTH, 4, data word width in bits
HOLD_CYCLES, 2, cycles dout is guaranteed stable after a load (0..255)

Ports:
clk  input  1  rising-edge clock
clear_n  input  1  synchronous, active-low reset
req  input  N_REQ  per-requester request level; held high until gnt seen
req_data  input  N_REQ*WIDTH  requester i word at bits [i*WIDTH +: WIDTH]
flush  input  1  clear shared register to 0; honoured only in IDLE
gnt  output  N_REQ  one-hot grant, high for exactly the LOAD cycle
gnt_id  output  $clog2(N_REQ)  index of last granted requester
dout  output  WIDTH  shared register contents
busy  output  1  high in LOAD and HOLD
valid  output  1  high while dout holds a granted word (HOLD, and IDLE until flush)

Behaviour:
- Reset: sampled on clk rising edge while clear_n=0; state=IDLE, ptr=0, dout=0, gnt=0, gnt_id=0, busy=0, valid=0, hold_cnt=0. Overrides everything, including mid-LOAD/HOLD; no grant is issued in the reset cycle.
- States: IDLE, LOAD, HOLD.
- IDLE, any req bit high:
  - winner = first set bit searching ptr, ptr+1, ..., wrapping modulo N_REQ.
  - latch winner into gnt_id; next state LOAD.
  - flush ignored when a req is pending (req wins).
- IDLE, no req and flush=1: dout<=0, valid<=0; stay IDLE.
- IDLE, no req and flush=0: stay IDLE; dout and valid unchanged.
- LOAD (exactly 1 cycle):
  - gnt[gnt_id]=1 (combinational from state), busy=1.
  - At the edge ending LOAD: dout<=req_data[gnt_id], valid<=1, ptr<=(gnt_id+1) mod N_REQ.
  - Data is taken even if req[gnt_id] fell during LOAD; the protocol forbids that, and the bench flags it.
  - Next state HOLD with hold_cnt=HOLD_CYCLES-1. If HOLD_CYCLES=0, next state is IDLE.
- HOLD:
  - busy=1, dout frozen, new requests are not sampled (they wait).
  - hold_cnt decrements each cycle; at hold_cnt=0 next state is IDLE.
- Throughput: one grant per 2+HOLD_CYCLES cycles under continuous requests (IDLE sample, LOAD, HOLD).
- Latency: req high in IDLE at edge E0 -> gnt during cycle E0..E1 -> dout valid after E1.
- A requester that keeps req high after its gnt is treated as a new request. Round-robin guarantees other pending requesters are served first.
- Requests only change arbitration outcome in IDLE. A req raised and dropped entirely within LOAD/HOLD is never granted.
- gnt is never multi-hot. gnt=0 in IDLE and HOLD.
- Pointer and winner arithmetic is modulo N_REQ; N_REQ need not be a power of two.

Decomposition:
- Shared package pipo_share_pkg holds:
  - state enum (IDLE=2'd0, LOAD=2'd1, HOLD=2'd2);
  - width helper for the index, $clog2(N_REQ);
  - the hold-counter width constant (8 bits).
- One natural sub-module: rr_pick, a combinational round-robin priority picker (req vector, ptr) -> (found, index).
- The shared register, with load enable and synchronous clear, stays inline in the top.

Test Plan:
(N_REQ=4, WIDTH=4, HOLD_CYCLES=2 throughout.)
1. Reset mid-HOLD: assert clear_n=0 one cycle -> next cycle state IDLE, dout=0000, valid=0, busy=0, ptr=0. With req=0100, first grant is to requester 2.
2. Single request: req=0010, req_data[1]=1011 -> gnt=0010 for one cycle, gnt_id=1. dout=1011 one cycle later, busy high 3 cycles, valid stays 1 afterwards.
3. Round-robin fairness: req=1111 held continuously with data 0001/0010/0100/1000 -> grants 0001, 0010, 0100, 1000, 0001 at 4-cycle spacing. dout follows the same sequence.
4. Wrap and skip: ptr=3 (after granting req 2), req=0011 -> grant to requester 0, then requester 1, never requester 3.
5. Flush vs request: in IDLE with valid=1, flush=1 and req=0 -> dout=0000, valid=0. Same cycle with req=1000 -> grant to requester 3, flush ignored.
6. Late request during HOLD: req 0 granted; req=0100 raised at the second HOLD cycle -> gnt=0100 exactly 2 cycles after entering IDLE's sampling edge; dout stable through both HOLD cycles.

Source files
------------

// File: rtl/pipo_share_arbiter_pkg.sv
// Shared types and constants for the pipo_share_arbiter block: FSM state
// encoding, hold-counter width and the index-width helper.
package pipo_share_pkg;

  // Arbiter FSM states. HOLD keeps the loaded word stable for the consumer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_e;

  // HOLD_CYCLES is limited to 0..255, so an 8-bit down-counter suffices.
  localparam int HOLD_CNT_W = 8;

  // Width of a requester index. This is never less than one bit, so that
  // degenerate widths cannot appear in port declarations.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipo_share_arbiter_if.sv
// Bus bundle between the requesters and the shared-register arbiter.
// The master side drives requests, words and flush. The slave side (the
// arbiter) drives grants and the shared output word.
interface pipo_share_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
);
  import pipo_share_pkg::*;

  localparam int IDX_W = idx_w(N_REQ);

  logic [N_REQ-1:0]       req;       // per-requester request level
  logic [N_REQ*WIDTH-1:0] req_data;  // requester i word at [i*WIDTH +: WIDTH]
  logic                   flush;     // clear shared register (IDLE only)
  logic [N_REQ-1:0]       gnt;       // one-hot grant, LOAD cycle only
  logic [IDX_W-1:0]       gnt_id;    // index of last granted requester
  logic [WIDTH-1:0]       dout;      // shared register contents
  logic                   busy;      // high in LOAD and HOLD
  logic                   valid;     // dout holds a granted word

  modport master (
    output req, req_data, flush,
    input  gnt, gnt_id, dout, busy, valid
  );

  modport slave (
    input  req, req_data, flush,
    output gnt, gnt_id, dout, busy, valid
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker. It returns the first asserted
// request found by searching from ptr_i upwards, wrapping modulo N_REQ.
// N_REQ does not have to be a power of two.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Scan candidates in priority order ptr, ptr+1, ... and keep the first hit.
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // up front. A path that leaves one unassigned would infer a latch.
    found_o  = 1'b0;
    idx_o    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      cand_idx = IDX_W'(cand);
      if (!found_o && req_i[cand_idx]) begin
        found_o = 1'b1;
        idx_o   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/pipo_share_arbiter.sv
// Round-robin arbiter that shares one WIDTH-bit holding register between
// N_REQ parallel word sources.
// IDLE samples requests and picks a winner. LOAD (one cycle) asserts the
// grant and captures the word. HOLD keeps dout frozen for HOLD_CYCLES cycles
// before arbitration resumes.
module pipo_share_arbiter
  import pipo_share_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 2
) (
  input logic                clk,
  input logic                clear_n,
  pipo_share_arbiter_if.slave bus
);

  localparam int IDX_W = idx_w(N_REQ);

  // HOLD is entered with the count of remaining cycles minus one, so that
  // HOLD lasts exactly HOLD_CYCLES cycles.
  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST =
    (HOLD_CYCLES > 0) ? HOLD_CNT_W'(HOLD_CYCLES - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  // FSM and arbitration state
  state_e                  state_q;
  logic [IDX_W-1:0]        ptr_q;
  logic [IDX_W-1:0]        gnt_id_q;
  logic [HOLD_CNT_W-1:0]   hold_cnt_q;
  logic [N_REQ-1:0]        gnt_q;
  logic                    busy_q;

  // Shared holding register
  logic [WIDTH-1:0]        dout_q, dout_d;
  logic                    valid_q, valid_d;

  // Picker results and derived controls
  logic                    pick_found;
  logic [IDX_W-1:0]        pick_idx;
  logic [N_REQ-1:0]        pick_onehot;
  logic [IDX_W-1:0]        ptr_next;
  logic [WIDTH-1:0]        load_word;
  logic                    load_en;
  logic                    clr_en;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign pick_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;

  // The pointer moves just past the granted requester, wrapping modulo N_REQ
  // even when N_REQ is not a power of two.
  assign ptr_next = (gnt_id_q == LAST_IDX) ? '0 : gnt_id_q + 1'b1;

  // Select the granted requester's word with a constant-index mux.
  always_comb begin
    load_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_id_q == IDX_W'(i)) begin
        load_word = bus.req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // FSM with registered grant/busy outputs. The reset branch overrides any
  // LOAD or HOLD in progress.
  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignments, so every
    // register in this block sees the pre-edge values of the others.
    if (!clear_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_id_q   <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            gnt_id_q <= pick_idx;
            gnt_q    <= pick_onehot;
            busy_q   <= 1'b1;
            state_q  <= LOAD;
          end
        end
        LOAD: begin
          gnt_q <= '0;
          ptr_q <= ptr_next;
          if (HOLD_CYCLES == 0) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            hold_cnt_q <= HOLD_LAST;
            state_q    <= HOLD;
          end
        end
        HOLD: begin
          if (hold_cnt_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            hold_cnt_q <= hold_cnt_q - 1'b1;
          end
        end
        default: begin
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Load and clear enables for the shared register. A pending request
  // takes priority over flush.
  assign load_en = (state_q == LOAD);
  assign clr_en  = (state_q == IDLE) && !pick_found && bus.flush;

  // Next value of the shared register: load, clear or hold.
  always_comb begin
    dout_d  = dout_q;
    valid_d = valid_q;
    if (load_en) begin
      dout_d  = load_word;
      valid_d = 1'b1;
    end else if (clr_en) begin
      dout_d  = '0;
      valid_d = 1'b0;
    end
  end

  // Shared holding register with synchronous clear.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.gnt_id = gnt_id_q;
  assign bus.dout   = dout_q;
  assign bus.busy   = busy_q;
  assign bus.valid  = valid_q;

endmodule

// File: tb/tb_pipo_share_arbiter.sv
// Testbench for pipo_share_arbiter.
// A reference model runs at the rising edge. It tracks when the shared
// register is free and which requester the round-robin order selects next,
// and it pushes each expected grant into a queue. A monitor on the falling
// edge pops that queue whenever a grant is due or seen. It also compares
// busy/valid/dout against the model on every cycle.
module tb_pipo_share_arbiter;
  import pipo_share_pkg::*;

  localparam int N = 4;
  localparam int W = 4;
  localparam int H = 2;

  logic clk = 1'b0;
  logic clear_n = 1'b0;
  always #5 clk = ~clk;

  pipo_share_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  pipo_share_arbiter #(
    .N_REQ       (N),
    .WIDTH       (W),
    .HOLD_CYCLES (H)
  ) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int id;
    int edge_no;
  } gnt_exp_t;

  gnt_exp_t       exp_q[$];
  int             edge_cnt   = 0;
  int             m_ptr      = 0;
  int             m_free_at  = 0;   // first edge at which requests are sampled again
  int             m_load_at  = -1;  // edge at which the granted word is captured
  int             m_load_id  = 0;
  logic [W-1:0]   exp_dout   = '0;
  logic           exp_valid  = 1'b0;
  logic           exp_busy   = 1'b0;

  always @(posedge clk) begin
    edge_cnt++;
    if (!clear_n) begin
      m_ptr     = 0;
      m_free_at = edge_cnt + 1;
      m_load_at = -1;
      exp_dout  = '0;
      exp_valid = 1'b0;
      exp_q.delete();
    end else begin
      if (edge_cnt == m_load_at) begin
        exp_dout  = bus.req_data[m_load_id*W +: W];
        exp_valid = 1'b1;
      end
      if (edge_cnt >= m_free_at) begin
        if (bus.req != '0) begin
          int win;
          win = -1;
          for (int k = 0; k < N; k++) begin
            if (win < 0 && bus.req[(m_ptr + k) % N]) win = (m_ptr + k) % N;
          end
          exp_q.push_back('{id: win, edge_no: edge_cnt});
          m_load_id = win;
          m_load_at = edge_cnt + 1;
          m_free_at = edge_cnt + 2 + H;
          m_ptr     = (win + 1) % N;
        end else if (bus.flush) begin
          exp_dout  = '0;
          exp_valid = 1'b0;
        end
      end
    end
    exp_busy = (edge_cnt < m_free_at - 1);
  end

  // ---------------- monitor / scoreboard ----------------
  gnt_exp_t mon_e;

  always @(negedge clk) begin
    check("busy",  32'(bus.busy),  32'(exp_busy));
    check("valid", 32'(bus.valid), 32'(exp_valid));
    check("dout",  32'(bus.dout),  32'(exp_dout));
    if (bus.gnt != '0 || (exp_q.size() > 0 && exp_q[0].edge_no <= edge_cnt)) begin
      if (exp_q.size() == 0) begin
        check("gnt_unexpected", 32'(bus.gnt), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("gnt",      32'(bus.gnt),    32'(1) << mon_e.id);
        check("gnt_id",   32'(bus.gnt_id), 32'(mon_e.id));
        check("gnt_time", 32'(edge_cnt),   32'(mon_e.edge_no));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_gnt(input string name, output logic [N-1:0] g);
    g = '0;
    for (int i = 0; i < 30 && g == '0; i++) begin
      @(negedge clk);
      g = bus.gnt;
    end
    if (g == '0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no grant seen within 30 cycles", name);
    end
  endtask

  logic [N-1:0] g;
  logic [N-1:0] prev_gnt;

  initial begin
    bus.req      = '0;
    bus.req_data = '0;
    bus.flush    = 1'b0;
    clear_n      = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_dout",   32'(bus.dout),   32'd0);
    check("rst_gnt_id", 32'(bus.gnt_id), 32'd0);
    clear_n = 1'b1;

    // Single request from requester 1.
    bus.req_data[1*W +: W] = 4'b1011;
    bus.req = 4'b0010;
    wait_gnt("single", g);
    check("single_gnt",    32'(g),          32'(4'b0010));
    check("single_gnt_id", 32'(bus.gnt_id), 32'd1);
    @(negedge clk);
    bus.req = '0;
    check("single_dout", 32'(bus.dout), 32'(4'b1011));
    repeat (4) @(negedge clk);
    check("single_valid_kept", 32'(bus.valid), 32'd1);

    // Reset in the middle of HOLD, then the first grant goes to requester 2.
    bus.req_data[0 +: W] = 4'b0110;
    bus.req = 4'b0001;
    wait_gnt("rst_mid", g);
    @(negedge clk);
    clear_n = 1'b0;
    bus.req = '0;
    @(negedge clk);
    check("rst_mid_dout",  32'(bus.dout),   32'd0);
    check("rst_mid_valid", 32'(bus.valid),  32'd0);
    check("rst_mid_busy",  32'(bus.busy),   32'd0);
    check("rst_mid_gnt",   32'(bus.gnt),    32'd0);
    clear_n = 1'b1;
    bus.req_data[2*W +: W] = 4'b1100;
    bus.req = 4'b0100;
    wait_gnt("after_rst", g);
    check("after_rst_gnt", 32'(g), 32'(4'b0100));
    @(negedge clk);
    bus.req = '0;

    // The pointer now sits at 3. Requests 0 and 1 are served in wrap order.
    bus.req = 4'b0011;
    wait_gnt("wrap0", g);
    check("wrap0_gnt", 32'(g), 32'(4'b0001));
    @(negedge clk);
    bus.req = 4'b0010;
    wait_gnt("wrap1", g);
    check("wrap1_gnt", 32'(g), 32'(4'b0010));
    @(negedge clk);
    bus.req = '0;

    // Fairness: all four requesters hold their requests high after a reset.
    clear_n = 1'b0;
    @(negedge clk);
    clear_n = 1'b1;
    bus.req_data = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt("rr", g);
      check("rr_gnt", 32'(g), 32'(1) << (k % N));
      @(negedge clk);
      check("rr_dout", 32'(bus.dout), 32'(1) << (k % N));
    end
    bus.req = '0;

    // Flush in IDLE with no requests clears the register.
    repeat (4) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_dout",  32'(bus.dout),  32'd0);
    check("flush_valid", 32'(bus.valid), 32'd0);

    // Flush alongside a request: the request wins.
    bus.req = 4'b0001;
    wait_gnt("reload", g);
    @(negedge clk);
    bus.req = '0;
    repeat (3) @(negedge clk);
    bus.flush = 1'b1;
    bus.req   = 4'b1000;
    wait_gnt("flush_vs_req", g);
    check("flush_vs_req_gnt", 32'(g), 32'(4'b1000));
    bus.flush = 1'b0;
    @(negedge clk);
    bus.req = '0;
    check("flush_vs_req_dout", 32'(bus.dout), 32'(4'b1000));

    // A request raised late in HOLD waits for the next IDLE sample.
    repeat (4) @(negedge clk);
    bus.req = 4'b0001;
    wait_gnt("late_a", g);
    @(negedge clk);
    bus.req = '0;
    check("late_hold1_dout", 32'(bus.dout), 32'(4'b0001));
    @(negedge clk);
    bus.req = 4'b0100;
    check("late_hold2_dout", 32'(bus.dout), 32'(4'b0001));
    wait_gnt("late_b", g);
    check("late_gnt", 32'(g), 32'(4'b0100));
    @(negedge clk);
    bus.req = '0;

    // Randomized traffic with occasional flush and reset.
    prev_gnt = '0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      clear_n   = ($urandom_range(0, 199) != 0);
      bus.flush = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < N; i++) begin
        if (bus.req[i] && prev_gnt[i]) begin
          if ($urandom_range(0, 2) != 0) bus.req[i] = 1'b0;
        end else if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
          bus.req_data[i*W +: W] = W'($urandom);
          bus.req[i] = 1'b1;
        end
      end
      prev_gnt = bus.gnt;
    end
    clear_n   = 1'b1;
    bus.flush = 1'b0;
    bus.req   = '0;
    repeat (10) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
